// File: rtl/types_pkg.sv
// Shared core types and constants for the RV32I pipeline.
package types_pkg;
  localparam int          DATA_BUS  = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;
endpackage

// File: rtl/fetch_skid.sv
// One-entry holding register for an instruction word that returns while decode is stalled.
module fetch_skid
  import types_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                i_clr,
  input  logic                i_load,
  input  logic                i_release,
  input  logic [DATA_BUS-1:0] i_instr,
  input  logic [DATA_BUS-1:0] i_pc,
  output logic                o_valid,
  output logic [DATA_BUS-1:0] o_instr,
  output logic [DATA_BUS-1:0] o_pc
);
  logic                r_valid;
  logic [DATA_BUS-1:0] r_instr;
  logic [DATA_BUS-1:0] r_pc;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end else if (i_release) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the fetch PC, drives a 1-cycle synchronous IMEM and the IF/ID register.
module fetch_stage
  import types_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                redirect,
  input  logic [DATA_BUS-1:0] redirect_target,
  output logic [DATA_BUS-1:0] imem_addr,
  output logic                imem_en,
  input  logic [DATA_BUS-1:0] imem_rdata,
  output logic [DATA_BUS-1:0] id_instr,
  output logic [DATA_BUS-1:0] id_pc,
  output logic [DATA_BUS-1:0] id_pc_plus4,
  output logic                id_valid
);
  logic [DATA_BUS-1:0] r_pc_f;
  logic                r_req_valid;
  logic [DATA_BUS-1:0] r_req_pc;
  logic                r_id_valid;
  logic [DATA_BUS-1:0] r_id_instr;
  logic [DATA_BUS-1:0] r_id_pc;
  logic [DATA_BUS-1:0] r_id_pc_plus4;

  logic                w_skid_valid;
  logic [DATA_BUS-1:0] w_skid_instr;
  logic [DATA_BUS-1:0] w_skid_pc;
  logic                w_skid_load;
  logic                w_advance;

  // The word returning during the first stall cycle is parked; later stall cycles issue nothing.
  assign w_skid_load = stall && !redirect && r_req_valid;
  assign w_advance   = !stall && !redirect;

  fetch_skid u_skid (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (redirect),
    .i_load    (w_skid_load),
    .i_release (w_advance),
    .i_instr   (imem_rdata),
    .i_pc      (r_req_pc),
    .o_valid   (w_skid_valid),
    .o_instr   (w_skid_instr),
    .o_pc      (w_skid_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc_f        <= RESET_PC;
      r_req_valid   <= 1'b0;
      r_req_pc      <= '0;
      r_id_valid    <= 1'b0;
      r_id_instr    <= NOP_INSTR;
      r_id_pc       <= '0;
      r_id_pc_plus4 <= '0;
    end else if (redirect) begin
      r_pc_f      <= {redirect_target[DATA_BUS-1:2], 2'b00};
      r_req_valid <= 1'b0;
      r_id_valid  <= 1'b0;
      r_id_instr  <= NOP_INSTR;
    end else if (stall) begin
      r_req_valid <= 1'b0;
    end else begin
      r_pc_f      <= r_pc_f + PC_STEP;
      r_req_valid <= 1'b1;
      r_req_pc    <= r_pc_f;
      if (w_skid_valid) begin
        r_id_valid    <= 1'b1;
        r_id_instr    <= w_skid_instr;
        r_id_pc       <= w_skid_pc;
        r_id_pc_plus4 <= w_skid_pc + PC_STEP;
      end else if (r_req_valid) begin
        r_id_valid    <= 1'b1;
        r_id_instr    <= imem_rdata;
        r_id_pc       <= r_req_pc;
        r_id_pc_plus4 <= r_req_pc + PC_STEP;
      end else begin
        r_id_valid <= 1'b0;
      end
    end
  end

  assign imem_en     = !rst && !stall;
  assign imem_addr   = r_pc_f;
  assign id_instr    = r_id_instr;
  assign id_pc       = r_id_pc;
  assign id_pc_plus4 = r_id_pc_plus4;
  assign id_valid    = r_id_valid;
endmodule

// File: tb/tb_fetch_stage.sv
// Table-driven check of fetch_stage against hand-derived per-cycle expectations.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_rdata;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        id_valid;

  int unsigned checks = 0;
  int unsigned errors = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem_addr       (imem_addr),
    .imem_en         (imem_en),
    .imem_rdata      (imem_rdata),
    .id_instr        (id_instr),
    .id_pc           (id_pc),
    .id_pc_plus4     (id_pc_plus4),
    .id_valid        (id_valid)
  );

  always #5 clk = ~clk;

  // Word at byte address a holds its word index, tagged so it never collides with NOP.
  function automatic logic [31:0] memword(input logic [31:0] a);
    return {2'b00, a[31:2]} ^ 32'h5A00_0000;
  endfunction

  always @(posedge clk) begin
    if (imem_en) imem_rdata <= memword(imem_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] tgt;
    logic [31:0] exp_addr;
    logic        exp_en;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic        exp_nop;
  } vec_t;

  vec_t vecs[28];

  function automatic vec_t mk(input logic s, input logic r, input logic [31:0] t,
                              input logic [31:0] a, input logic e, input logic v,
                              input logic [31:0] p, input logic n);
    vec_t x;
    x.stall = s; x.redir = r; x.tgt = t; x.exp_addr = a; x.exp_en = e;
    x.exp_valid = v; x.exp_pc = p; x.exp_nop = n;
    return x;
  endfunction

  // Inputs apply for one cycle; addr/en checked before the edge, IF/ID checked after it.
  task automatic run_vec(input int unsigned k, input vec_t v);
    string tag;
    tag = $sformatf("c%0d", k);
    stall = v.stall;
    redirect = v.redir;
    redirect_target = v.tgt;
    #1;
    chk({tag, "_imem_addr"}, imem_addr, v.exp_addr);
    chk({tag, "_imem_en"}, {31'd0, imem_en}, {31'd0, v.exp_en});
    @(posedge clk);
    #1;
    chk({tag, "_id_valid"}, {31'd0, id_valid}, {31'd0, v.exp_valid});
    if (v.exp_valid) begin
      chk({tag, "_id_pc"}, id_pc, v.exp_pc);
      chk({tag, "_id_instr"}, id_instr, memword(v.exp_pc));
      chk({tag, "_id_pc_plus4"}, id_pc_plus4, v.exp_pc + 32'd4);
    end
    if (v.exp_nop) chk({tag, "_id_instr_nop"}, id_instr, NOP);
  endtask

  initial begin
    //                 stall redir target         addr          en valid pc            nop
    vecs[0]  = mk(1'b0, 1'b0, 32'h0,         32'h0000_0000, 1'b1, 1'b0, 32'h0,         1'b1);
    vecs[1]  = mk(1'b0, 1'b0, 32'h0,         32'h0000_0004, 1'b1, 1'b1, 32'h0000_0000, 1'b0);
    vecs[2]  = mk(1'b0, 1'b0, 32'h0,         32'h0000_0008, 1'b1, 1'b1, 32'h0000_0004, 1'b0);
    vecs[3]  = mk(1'b0, 1'b0, 32'h0,         32'h0000_000C, 1'b1, 1'b1, 32'h0000_0008, 1'b0);
    vecs[4]  = mk(1'b1, 1'b0, 32'h0,         32'h0000_0010, 1'b0, 1'b1, 32'h0000_0008, 1'b0);
    vecs[5]  = mk(1'b1, 1'b0, 32'h0,         32'h0000_0010, 1'b0, 1'b1, 32'h0000_0008, 1'b0);
    vecs[6]  = mk(1'b1, 1'b0, 32'h0,         32'h0000_0010, 1'b0, 1'b1, 32'h0000_0008, 1'b0);
    vecs[7]  = mk(1'b0, 1'b0, 32'h0,         32'h0000_0010, 1'b1, 1'b1, 32'h0000_000C, 1'b0);
    vecs[8]  = mk(1'b0, 1'b0, 32'h0,         32'h0000_0014, 1'b1, 1'b1, 32'h0000_0010, 1'b0);
    vecs[9]  = mk(1'b0, 1'b0, 32'h0,         32'h0000_0018, 1'b1, 1'b1, 32'h0000_0014, 1'b0);
    vecs[10] = mk(1'b0, 1'b1, 32'h0000_0100, 32'h0000_001C, 1'b1, 1'b0, 32'h0,         1'b1);
    vecs[11] = mk(1'b0, 1'b0, 32'h0,         32'h0000_0100, 1'b1, 1'b0, 32'h0,         1'b0);
    vecs[12] = mk(1'b0, 1'b0, 32'h0,         32'h0000_0104, 1'b1, 1'b1, 32'h0000_0100, 1'b0);
    vecs[13] = mk(1'b0, 1'b0, 32'h0,         32'h0000_0108, 1'b1, 1'b1, 32'h0000_0104, 1'b0);
    vecs[14] = mk(1'b1, 1'b1, 32'h0000_0040, 32'h0000_010C, 1'b0, 1'b0, 32'h0,         1'b1);
    vecs[15] = mk(1'b0, 1'b0, 32'h0,         32'h0000_0040, 1'b1, 1'b0, 32'h0,         1'b0);
    vecs[16] = mk(1'b0, 1'b0, 32'h0,         32'h0000_0044, 1'b1, 1'b1, 32'h0000_0040, 1'b0);
    vecs[17] = mk(1'b1, 1'b0, 32'h0,         32'h0000_0048, 1'b0, 1'b1, 32'h0000_0040, 1'b0);
    vecs[18] = mk(1'b1, 1'b1, 32'h0000_0103, 32'h0000_0048, 1'b0, 1'b0, 32'h0,         1'b1);
    vecs[19] = mk(1'b0, 1'b0, 32'h0,         32'h0000_0100, 1'b1, 1'b0, 32'h0,         1'b0);
    vecs[20] = mk(1'b0, 1'b0, 32'h0,         32'h0000_0104, 1'b1, 1'b1, 32'h0000_0100, 1'b0);
    vecs[21] = mk(1'b0, 1'b0, 32'h0,         32'h0000_0108, 1'b1, 1'b1, 32'h0000_0104, 1'b0);
    vecs[22] = mk(1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0000_010C, 1'b1, 1'b0, 32'h0,         1'b1);
    vecs[23] = mk(1'b0, 1'b0, 32'h0,         32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0,         1'b0);
    vecs[24] = mk(1'b0, 1'b0, 32'h0,         32'h0000_0000, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
    vecs[25] = mk(1'b0, 1'b0, 32'h0,         32'h0000_0004, 1'b1, 1'b1, 32'h0000_0000, 1'b0);
    vecs[26] = mk(1'b0, 1'b0, 32'h0,         32'h0000_0008, 1'b1, 1'b1, 32'h0000_0004, 1'b0);
    vecs[27] = mk(1'b1, 1'b0, 32'h0,         32'h0000_000C, 1'b0, 1'b1, 32'h0000_0004, 1'b0);

    rst = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_target = '0;
    imem_rdata = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_imem_en", {31'd0, imem_en}, 32'd0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_id_instr", id_instr, NOP);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_id_pc_plus4", id_pc_plus4, 32'h0);
    rst = 1'b0;

    for (int unsigned k = 0; k < 28; k++) run_vec(k, vecs[k]);

    // Reset lands while stalled with the skid holding pc 8.
    rst = 1'b1;
    stall = 1'b1;
    #1;
    chk("midrst_imem_en", {31'd0, imem_en}, 32'd0);
    @(posedge clk);
    #1;
    chk("midrst_id_valid", {31'd0, id_valid}, 32'd0);
    chk("midrst_id_instr", id_instr, NOP);
    chk("midrst_id_pc", id_pc, 32'h0);
    chk("midrst_id_pc_plus4", id_pc_plus4, 32'h0);
    chk("midrst_imem_addr", imem_addr, 32'h0);
    rst = 1'b0;
    for (int unsigned k = 0; k < 3; k++) run_vec(100 + k, vecs[k]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
